// File: rtl/counter_pkg.sv
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared definitions for the counter_nb block: saturate-mode
//                constants, the decoded per-cycle step type and the helper
//                that derives the effective modulus M from WIDTH/MODULUS.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    // Values accepted by the SATURATE parameter of counter_nb.
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Action selected for the current cycle once clr has been excluded.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_LOAD = 2'd3
    } step_e;

    // Effective modulus: MODULUS of 0 selects the full binary range.
    // 64-bit result so that 2**32 is representable for WIDTH = 32.
    function automatic longint calc_modulus(input int width, input longint modulus);
        if (modulus == 0) begin
            return longint'(1) << width;
        end
        return modulus;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_nb_toggle_cell.sv
// ============================================================================
//  Module      : toggle_cell
//  Description : One bit of counter state held as a T flip-flop with a
//                synchronous clear. The bit inverts on every rising edge
//                where i_t is high.
//  Ports       : clk  - clock
//                rst  - synchronous active-high clear (forces o_q to 0)
//                i_t  - toggle request
//                o_q  - registered bit value
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_cell (
    input  logic clk,
    input  logic rst,
    input  logic i_t,
    output logic o_q
);

    logic r_state_q;
    logic w_state_d;

    always_comb begin
        w_state_d = r_state_q;
        if (i_t) begin
            w_state_d = ~r_state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    assign o_q = r_state_q;

endmodule

`default_nettype wire

// File: rtl/counter_nb.sv
// ============================================================================
//  Module      : counter_nb
//  Description : Modulo-M up/down counter with parallel load, optional
//                saturation, combinational terminal count and a registered
//                overflow pulse. Each count bit lives in a toggle_cell that
//                flips whenever the next count differs from the current one.
//  Ports       : clk  - clock, all state changes on the rising edge
//                clr  - synchronous active-high reset (Q and ovf to 0)
//                T    - count enable
//                up   - direction, 1 = increment, 0 = decrement
//                load - synchronous parallel load of d (clamped to M-1)
//                d    - load value
//                Q    - registered count, always in 0..M-1
//                tc   - T high and Q at the terminal value for direction
//                ovf  - one-cycle pulse after a wrap or a blocked step
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_nb
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 0,
    parameter int     SATURATE = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             T,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);

    localparam longint           c_M   = calc_modulus(WIDTH, MODULUS);
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(c_M - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "counter_nb: WIDTH=%0d outside 2..32", WIDTH);
        end
        if (MODULUS != 0 && (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH))) begin : g_bad_modulus
            $fatal(1, "counter_nb: MODULUS=%0d illegal for WIDTH=%0d", MODULUS, WIDTH);
        end
        if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_saturate
            $fatal(1, "counter_nb: SATURATE=%0d must be 0 or 1", SATURATE);
        end
    endgenerate

    logic [WIDTH-1:0] w_q_d;
    logic [WIDTH-1:0] w_toggle;
    logic             w_ovf_d;
    logic             r_ovf_q;
    logic             w_at_max;
    logic             w_at_zero;
    step_e            w_step;

    assign w_at_max  = (Q == c_MAX);
    assign w_at_zero = (Q == '0);

    // Load outranks counting; clr is handled separately in the next-state logic.
    always_comb begin
        w_step = STEP_HOLD;
        if (load) begin
            w_step = STEP_LOAD;
        end else if (T) begin
            w_step = up ? STEP_UP : STEP_DOWN;
        end
    end

    // Next count and overflow. Terminal steps never leave 0..M-1: they either
    // wrap to the opposite terminal or hold, and flag ovf in both cases.
    always_comb begin
        w_q_d   = Q;
        w_ovf_d = 1'b0;
        if (clr) begin
            w_q_d = '0;
        end else begin
            case (w_step)
                STEP_LOAD: begin
                    w_q_d = (d > c_MAX) ? c_MAX : d;
                end
                STEP_UP: begin
                    if (w_at_max) begin
                        w_ovf_d = 1'b1;
                        if (SATURATE == MODE_WRAP) begin
                            w_q_d = '0;
                        end
                    end else begin
                        w_q_d = Q + WIDTH'(1);
                    end
                end
                STEP_DOWN: begin
                    if (w_at_zero) begin
                        w_ovf_d = 1'b1;
                        if (SATURATE == MODE_WRAP) begin
                            w_q_d = c_MAX;
                        end
                    end else begin
                        w_q_d = Q - WIDTH'(1);
                    end
                end
                default: begin
                    w_q_d = Q;
                end
            endcase
        end
    end

    // Each cell flips exactly the bits that differ between current and next count.
    assign w_toggle = w_q_d ^ Q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            toggle_cell u_cell (
                .clk (clk),
                .rst (clr),
                .i_t (w_toggle[i]),
                .o_q (Q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            r_ovf_q <= 1'b0;
        end else begin
            r_ovf_q <= w_ovf_d;
        end
    end

    assign ovf = r_ovf_q;

    // Terminal count looks only at T, up and Q, so load and clr do not mask it.
    assign tc = T & (up ? w_at_max : w_at_zero);

endmodule

`default_nettype wire
